// File: rtl/gtp_link_seq.sv
// Supervised reset/bring-up sequencer for the GTP serial link (tx_clk domain).
// Optional LOS drop statistics are built when GTP_LINK_SEQ_STATS_EN is defined.
module gtp_link_seq #(
   parameter int HOLD_CYCLES  = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int SYNC_TIMEOUT = 65536,
   parameter int LOS_FILTER   = 256,
   parameter int MAX_RETRY    = 15
) (
   input  logic        tx_clk,
   input  logic        reset_n,
   input  logic        plllkdet,
   input  logic        rx_err_los,
   input  logic        sw_reset,
   output logic        gtp_reset,
   output logic        rx_reset,
   output logic        link_up,
   output logic        fail,
   output logic [2:0]  state,
   output logic [3:0]  retry_count,
   output logic [15:0] los_events
);

   localparam int MAX_A  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B  = (SYNC_TIMEOUT > LOS_FILTER) ? SYNC_TIMEOUT : LOS_FILTER;
   localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W  = $clog2(MAX_P + 1);
   localparam int FLT_W  = $clog2(LOS_FILTER + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_TIMEOUT - 1);
   localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOS_FILTER - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RX_RST    = 3'd2,
      S_WAIT_SYNC = 3'd3,
      S_UP        = 3'd4,
      S_FAIL      = 3'd5
   } seq_state_t;

   seq_state_t       st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FLT_W-1:0] flt_q, flt_d;
   logic [3:0]       retry_q, retry_d;
   logic             retry_evt;
   logic             restart;
   logic             los_p0, los_s;
   logic             gtp_reset_q, rx_reset_q, link_up_q, fail_q;
   logic             gtp_reset_d, rx_reset_d, link_up_d, fail_d;

   // LOS synchroniser stage boundary: rx_clk domain into tx_clk
   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         los_p0 <= 1'b1;
         los_s  <= 1'b1;
      end else begin
         los_p0 <= rx_err_los;
         los_s  <= los_p0;
      end
   end

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q        <= S_HOLD;
         cnt_q       <= '0;
         flt_q       <= '0;
         retry_q     <= '0;
         gtp_reset_q <= 1'b1;
         rx_reset_q  <= 1'b1;
         link_up_q   <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         flt_q       <= flt_d;
         retry_q     <= retry_d;
         gtp_reset_q <= gtp_reset_d;
         rx_reset_q  <= rx_reset_d;
         link_up_q   <= link_up_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      retry_d   = retry_q;
      retry_evt = 1'b0;
      case (st_q)
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) st_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (plllkdet)                st_d = S_RX_RST;
            else if (cnt_q == LOCK_LAST) retry_evt = 1'b1;
         end
         S_RX_RST: begin
            if (!plllkdet)               retry_evt = 1'b1;
            else if (cnt_q == HOLD_LAST) st_d = S_WAIT_SYNC;
         end
         S_WAIT_SYNC: begin
            if (!plllkdet) begin
               retry_evt = 1'b1;
            end else if (!los_s && flt_q == FLT_LAST) begin
               st_d    = S_UP;
               retry_d = '0;
            end else if (cnt_q == SYNC_LAST) begin
               retry_evt = 1'b1;
            end
         end
         S_UP: begin
            // lock loss and filter expiry together still form one attempt
            if (!plllkdet || (los_s && flt_q == FLT_LAST)) retry_evt = 1'b1;
         end
         S_FAIL: begin
            st_d = S_FAIL;
         end
         default: st_d = S_HOLD;
      endcase

      if (retry_evt) begin
         if (retry_q == RETRY_MAX) begin
            st_d = S_FAIL;
         end else begin
            st_d    = S_HOLD;
            retry_d = retry_q + 4'd1;
         end
      end

      if (sw_reset) begin
         st_d    = S_HOLD;
         retry_d = '0;
      end

      restart = sw_reset || (st_d != st_q);

      if (restart)                             cnt_d = '0;
      else if (st_q == S_UP || st_q == S_FAIL) cnt_d = cnt_q;
      else                                     cnt_d = cnt_q + 1'b1;

      if (restart)                                flt_d = '0;
      else if (st_q == S_WAIT_SYNC && !los_s)     flt_d = flt_q + 1'b1;
      else if (st_q == S_UP && los_s)             flt_d = flt_q + 1'b1;
      else                                        flt_d = '0;

      // outputs are registered from the next state so they track state exactly
      gtp_reset_d = (st_d == S_HOLD) || (st_d == S_FAIL);
      rx_reset_d  = (st_d != S_WAIT_SYNC) && (st_d != S_UP);
      link_up_d   = (st_d == S_UP);
      fail_d      = (st_d == S_FAIL);
   end

   assign gtp_reset   = gtp_reset_q;
   assign rx_reset    = rx_reset_q;
   assign link_up     = link_up_q;
   assign fail        = fail_q;
   assign state       = st_q;
   assign retry_count = retry_q;

`ifdef GTP_LINK_SEQ_STATS_EN
   logic [15:0] los_events_q;
   logic        drop_evt;

   // leaving UP without a software restart can only be a retry
   assign drop_evt = (st_q == S_UP) && (st_d != S_UP) && !sw_reset;

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n)
         los_events_q <= '0;
      else if (drop_evt && los_events_q != 16'hFFFF)
         los_events_q <= los_events_q + 16'd1;
   end

   assign los_events = los_events_q;
`else
   assign los_events = '0;
`endif

endmodule

// File: tb/tb_gtp_link_seq.sv
// Directed bench for gtp_link_seq with short timing parameters.
module tb_gtp_link_seq;

`ifdef GTP_LINK_SEQ_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        tx_clk;
   logic        reset_n;
   logic        plllkdet;
   logic        rx_err_los;
   logic        sw_reset;
   logic        gtp_reset;
   logic        rx_reset;
   logic        link_up;
   logic        fail;
   logic [2:0]  state;
   logic [3:0]  retry_count;
   logic [15:0] los_events;

   int n_tests = 0;
   int n_fail  = 0;

   gtp_link_seq #(
      .HOLD_CYCLES (4),
      .LOCK_TIMEOUT(32),
      .SYNC_TIMEOUT(64),
      .LOS_FILTER  (8),
      .MAX_RETRY   (2)
   ) dut (
      .tx_clk     (tx_clk),
      .reset_n    (reset_n),
      .plllkdet   (plllkdet),
      .rx_err_los (rx_err_los),
      .sw_reset   (sw_reset),
      .gtp_reset  (gtp_reset),
      .rx_reset   (rx_reset),
      .link_up    (link_up),
      .fail       (fail),
      .state      (state),
      .retry_count(retry_count),
      .los_events (los_events)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   task automatic step(input int n);
      repeat (n) @(posedge tx_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_up(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (link_up !== 1'b1 && n < 300) begin
         step(1);
         n++;
      end
      chk(tag, n, exp_cycles);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_gtp_reset"}, gtp_reset, 1);
      chk({tag, "_rx_reset"}, rx_reset, 1);
      chk({tag, "_link_up"}, link_up, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_retry"}, retry_count, 0);
      chk({tag, "_los_events"}, los_events, 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      plllkdet   = 1'b1;
      rx_err_los = 1'b0;
      sw_reset   = 1'b0;
      step(2);
      chk_reset_vals("rst");

      // clean bring-up
      reset_n = 1'b1;
      step(3);
      chk("boot_gtp_hold", gtp_reset, 1);
      step(1);
      chk("boot_gtp_fall", gtp_reset, 0);
      chk("boot_wait_lock", state, 1);
      step(1);
      chk("boot_rx_rst", state, 2);
      step(3);
      chk("boot_rx_hold", rx_reset, 1);
      step(1);
      chk("boot_rx_fall", rx_reset, 0);
      chk("boot_wait_sync", state, 3);
      step(7);
      chk("boot_not_up_yet", link_up, 0);
      step(1);
      chk("boot_link_up", link_up, 1);
      chk("boot_state_up", state, 4);
      chk("boot_retry", retry_count, 0);

      // 7-cycle LOS glitch is filtered
      rx_err_los = 1'b1;
      step(7);
      rx_err_los = 1'b0;
      step(12);
      chk("glitch7_link", link_up, 1);
      chk("glitch7_state", state, 4);

      // 8-cycle LOS pulse drops the link
      rx_err_los = 1'b1;
      step(8);
      rx_err_los = 1'b0;
      step(1);
      chk("los8_still_up", link_up, 1);
      step(1);
      chk("los8_link_drop", link_up, 0);
      chk("los8_state", state, 0);
      chk("los8_retry", retry_count, 1);
      chk("los8_events", los_events, STATS ? 1 : 0);
      wait_up("los8_recover_cycles", 17);
      chk("los8_recover_retry", retry_count, 0);

      // single-cycle lock loss in UP
      plllkdet = 1'b0;
      step(1);
      plllkdet = 1'b1;
      chk("lock_loss_state", state, 0);
      chk("lock_loss_link", link_up, 0);
      chk("lock_loss_retry", retry_count, 1);
      chk("lock_loss_events", los_events, STATS ? 2 : 0);
      wait_up("lock_loss_recover_cycles", 17);

      // sw_reset coincident with LOS filter expiry
      rx_err_los = 1'b1;
      step(9);
      chk("swlos_before_exp", link_up, 1);
      sw_reset = 1'b1;
      step(1);
      sw_reset   = 1'b0;
      rx_err_los = 1'b0;
      chk("swlos_state", state, 0);
      chk("swlos_retry", retry_count, 0);
      chk("swlos_events", los_events, STATS ? 2 : 0);
      wait_up("swlos_recover_cycles", 17);

      // no lock: retries exhaust into FAIL
      plllkdet = 1'b0;
      sw_reset = 1'b1;
      step(1);
      sw_reset = 1'b0;
      chk("nolock_start_state", state, 0);
      chk("nolock_start_retry", retry_count, 0);
      step(35);
      chk("nolock_wl1", state, 1);
      step(1);
      chk("nolock_retry1_state", state, 0);
      chk("nolock_retry1", retry_count, 1);
      step(4);
      chk("nolock_wl2", state, 1);
      step(32);
      chk("nolock_retry2", retry_count, 2);
      chk("nolock_retry2_state", state, 0);
      step(35);
      chk("nolock_wl3", state, 1);
      step(1);
      chk("nolock_fail_state", state, 5);
      chk("nolock_fail", fail, 1);
      chk("nolock_fail_gtp", gtp_reset, 1);
      chk("nolock_fail_rx", rx_reset, 1);
      chk("nolock_fail_link", link_up, 0);
      chk("nolock_fail_retry", retry_count, 2);
      plllkdet = 1'b1;
      step(1000);
      chk("fail_sticky_state", state, 5);
      chk("fail_sticky_fail", fail, 1);
      chk("fail_sticky_gtp", gtp_reset, 1);

      // restart from FAIL
      sw_reset = 1'b1;
      step(1);
      sw_reset = 1'b0;
      chk("restart_state", state, 0);
      chk("restart_fail", fail, 0);
      chk("restart_retry", retry_count, 0);
      chk("restart_gtp", gtp_reset, 1);
      chk("restart_events_kept", los_events, STATS ? 2 : 0);
      wait_up("restart_up_cycles", 17);

      // asynchronous reset mid-WAIT_SYNC
      sw_reset = 1'b1;
      step(1);
      sw_reset = 1'b0;
      step(12);
      chk("async_in_wait_sync", state, 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async");
      reset_n = 1'b1;
      wait_up("async_rebuild_cycles", 17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
